// File: rtl/clk_div_pkg.sv
// Shared types for the clock divider bank: divider mode and per-channel configuration record.
package clk_div_pkg;

  localparam int MAX_DIV_W = 16;

  typedef enum logic {
    MODE_POW2   = 1'b0,
    MODE_LINEAR = 1'b1
  } mode_e;

  typedef struct packed {
    logic [MAX_DIV_W-1:0] div;
    mode_e                mode;
  } cfg_t;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, tick/square outputs, glitch-free config handover.
// Square output exists only when CLK_DIV_SQUARE_EN is defined.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic wr,
  input  cfg_t wr_cfg,
  output logic tick_out,
  output logic sq_out,
  output logic pending
);

  localparam int EXP_W = $clog2(DIV_W);
  localparam int TW    = MAX_DIV_W + 1;

  logic [DIV_W-1:0] cnt;
  cfg_t             act_cfg;
  cfg_t             pend_cfg;
  logic [EXP_W-1:0] exp_raw;
  logic [EXP_W-1:0] exp_mod;
  logic [TW-1:0]    term;
  logic             tc;

  // term = P-1; the POW2 exponent is the low bits of div folded back below DIV_W
  always_comb begin
    exp_raw = act_cfg.div[EXP_W-1:0];
    exp_mod = (int'(exp_raw) >= DIV_W) ? exp_raw - EXP_W'(DIV_W) : exp_raw;
    if (act_cfg.mode == MODE_POW2) term = (TW'(1) << exp_mod) - TW'(1);
    else                           term = TW'(act_cfg.div);
    tc = (TW'(cnt) == term);
  end

`ifdef CLK_DIV_SQUARE_EN
  logic [TW-1:0] half;
  logic          sq_next;

  always_comb begin
    half    = (term + TW'(1)) >> 1;
    sq_next = (TW'(cnt) < half);
  end

  always_ff @(posedge clk) begin
    if (rst) sq_out <= 1'b0;
    else     sq_out <= en & sq_next;
  end
`else
  assign sq_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      act_cfg  <= '0;
      pend_cfg <= '0;
      pending  <= 1'b0;
      tick_out <= 1'b0;
    end else begin
      tick_out <= en & tc;
      if (!en) begin
        // idle: older pending config lands now, a fresh write queues behind it
        cnt <= '0;
        if (pending) act_cfg <= pend_cfg;
        if (wr) pend_cfg <= wr_cfg;
        pending <= wr;
      end else if (tc) begin
        cnt <= '0;
        if (wr) begin
          act_cfg <= wr_cfg;
          pending <= 1'b0;
        end else if (pending) begin
          act_cfg <= pend_cfg;
          pending <= 1'b0;
        end
      end else begin
        cnt <= cnt + 1'b1;
        if (wr) begin
          pend_cfg <= wr_cfg;
          pending  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH independent clock dividers with a shared write port.
// Define CLK_DIV_SQUARE_EN to generate sq_out; otherwise sq_out is tied low.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       wr,
  input  logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] wr_ch,
  input  logic                                       wr_mode,
  input  logic [DIV_W-1:0]                           wr_div,
  input  logic [NUM_CH-1:0]                          en,
  output logic [NUM_CH-1:0]                          tick_out,
  output logic [NUM_CH-1:0]                          sq_out,
  output logic [NUM_CH-1:0]                          pending
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  cfg_t wr_cfg;

  always_comb begin
    wr_cfg      = '0;
    wr_cfg.div  = MAX_DIV_W'(wr_div);
    wr_cfg.mode = mode_e'(wr_mode);
  end

  // an out-of-range wr_ch matches no instance index, so such writes vanish
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_channel #(
      .DIV_W(DIV_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en[i]),
      .wr      (wr && (wr_ch == CH_W'(i))),
      .wr_cfg  (wr_cfg),
      .tick_out(tick_out[i]),
      .sq_out  (sq_out[i]),
      .pending (pending[i])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: directed vector table, corner sequences, random run vs period model.
module tb_clk_div_bank;

  localparam int NCH = 5;
  localparam int DW  = 8;
`ifdef CLK_DIV_SQUARE_EN
  localparam bit SQ = 1'b1;
`else
  localparam bit SQ = 1'b0;
`endif

  logic           clk;
  logic           rst;
  logic           wr;
  logic [2:0]     wr_ch;
  logic           wr_mode;
  logic [DW-1:0]  wr_div;
  logic [NCH-1:0] en;
  logic [NCH-1:0] tick_out;
  logic [NCH-1:0] sq_out;
  logic [NCH-1:0] pending;

  clk_div_bank #(
    .NUM_CH(NCH),
    .DIV_W (DW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr      (wr),
    .wr_ch   (wr_ch),
    .wr_mode (wr_mode),
    .wr_div  (wr_div),
    .en      (en),
    .tick_out(tick_out),
    .sq_out  (sq_out),
    .pending (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model: each channel tracks its period and the cycle its count restarted
  int             per    [NCH];
  int             start  [NCH];
  bit             pend_m [NCH];
  int             pdiv   [NCH];
  bit             pmode  [NCH];
  logic [NCH-1:0] e_tick, e_sq, e_pend;
  int             cyc = 0;

  function automatic int period(int d, bit m);
    return m ? d + 1 : (1 << (d % DW));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step(input logic r, input logic w, input logic [2:0] ch,
                            input logic m, input logic [7:0] d, input logic [NCH-1:0] e);
    for (int i = 0; i < NCH; i++) begin
      if (r) begin
        per[i] = 1; start[i] = cyc + 1; pend_m[i] = 0;
        e_tick[i] = 0; e_sq[i] = 0; e_pend[i] = 0;
      end else begin
        int ph;
        bit tc, wi;
        ph = (cyc - start[i]) % per[i];
        tc = e[i] && (ph == per[i] - 1);
        wi = w && (int'(ch) == i);
        e_tick[i] = tc;
        e_sq[i]   = SQ && e[i] && (ph < per[i] / 2);
        if (!e[i]) begin
          if (pend_m[i]) per[i] = period(pdiv[i], pmode[i]);
          pend_m[i] = wi;
          if (wi) begin pdiv[i] = d; pmode[i] = m; end
          start[i] = cyc + 1;
        end else if (tc) begin
          if (wi) per[i] = period(d, m);
          else if (pend_m[i]) per[i] = period(pdiv[i], pmode[i]);
          pend_m[i] = 0;
          start[i]  = cyc + 1;
        end else if (wi) begin
          pend_m[i] = 1; pdiv[i] = d; pmode[i] = m;
        end
        e_pend[i] = pend_m[i];
      end
    end
    cyc++;
  endtask

  task automatic cycle(input logic r, input logic w, input logic [2:0] ch,
                       input logic m, input logic [7:0] d, input logic [NCH-1:0] e);
    rst = r; wr = w; wr_ch = ch; wr_mode = m; wr_div = d; en = e;
    model_step(r, w, ch, m, d, e);
    @(posedge clk);
    #1;
    chk("tick", 32'(tick_out), 32'(e_tick));
    chk("sq",   32'(sq_out),   32'(e_sq));
    chk("pend", 32'(pending),  32'(e_pend));
  endtask

  typedef struct {
    logic r, w; logic [2:0] ch; logic m; logic [7:0] d; logic [NCH-1:0] e;
    logic t, s, p;
  } vec_t;

  vec_t tbl[27];

  initial begin
    logic [NCH-1:0] en_r;
    rst = 1'b1; wr = 1'b0; wr_ch = '0; wr_mode = 1'b0; wr_div = '0; en = '0;

    // ch0 LINEAR div=4 (P=5), then a write landing on its TC: LINEAR div=7 (P=8)
    tbl[0]  = '{1'b1, 1'b0, 3'd0, 1'b0, 8'd0, 5'b00000, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 3'd0, 1'b1, 8'd4, 5'b00000, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 3'd0, 1'b0, 8'd0, 5'b00000, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 3'd0, 1'b0, 8'd0, 5'b00001, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 3'd0, 1'b0, 8'd0, 5'b00001, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 3'd0, 1'b0, 8'd0, 5'b00001, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 3'd0, 1'b0, 8'd0, 5'b00001, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 3'd0, 1'b0, 8'd0, 5'b00001, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 3'd0, 1'b0, 8'd0, 5'b00001, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 3'd0, 1'b0, 8'd0, 5'b00001, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 3'd0, 1'b0, 8'd0, 5'b00001, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 3'd0, 1'b0, 8'd0, 5'b00001, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 3'd0, 1'b0, 8'd0, 5'b00001, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 3'd0, 1'b0, 8'd0, 5'b00001, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 3'd0, 1'b0, 8'd0, 5'b00001, 1'b0, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 3'd0, 1'b0, 8'd0, 5'b00001, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 3'd0, 1'b0, 8'd0, 5'b00001, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 3'd0, 1'b1, 8'd7, 5'b00001, 1'b1, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 3'd0, 1'b0, 8'd0, 5'b00001, 1'b0, 1'b1, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 3'd0, 1'b0, 8'd0, 5'b00001, 1'b0, 1'b1, 1'b0};
    tbl[20] = '{1'b0, 1'b0, 3'd0, 1'b0, 8'd0, 5'b00001, 1'b0, 1'b1, 1'b0};
    tbl[21] = '{1'b0, 1'b0, 3'd0, 1'b0, 8'd0, 5'b00001, 1'b0, 1'b1, 1'b0};
    tbl[22] = '{1'b0, 1'b0, 3'd0, 1'b0, 8'd0, 5'b00001, 1'b0, 1'b0, 1'b0};
    tbl[23] = '{1'b0, 1'b0, 3'd0, 1'b0, 8'd0, 5'b00001, 1'b0, 1'b0, 1'b0};
    tbl[24] = '{1'b0, 1'b0, 3'd0, 1'b0, 8'd0, 5'b00001, 1'b0, 1'b0, 1'b0};
    tbl[25] = '{1'b0, 1'b0, 3'd0, 1'b0, 8'd0, 5'b00001, 1'b1, 1'b0, 1'b0};
    tbl[26] = '{1'b0, 1'b0, 3'd0, 1'b0, 8'd0, 5'b00001, 1'b0, 1'b1, 1'b0};

    for (int k = 0; k < 27; k++) begin
      cycle(tbl[k].r, tbl[k].w, tbl[k].ch, tbl[k].m, tbl[k].d, tbl[k].e);
      chk("tbl_tick0", 32'(tick_out[0]), 32'(tbl[k].t));
      chk("tbl_sq0",   32'(sq_out[0]),   32'(tbl[k].s & SQ));
      chk("tbl_pend0", 32'(pending[0]),  32'(tbl[k].p));
    end

    // ch1 POW2 div=3 running, rewritten to div=1 mid-period
    cycle(0, 1, 3'd1, 0, 8'd3, 5'b00000);
    cycle(0, 0, 3'd0, 0, 8'd0, 5'b00000);
    for (int k = 0; k < 3; k++) cycle(0, 0, 3'd0, 0, 8'd0, 5'b00010);
    cycle(0, 1, 3'd1, 0, 8'd1, 5'b00010);
    chk("ch1_pend_mid", 32'(pending[1]), 32'd1);
    for (int k = 0; k < 12; k++) cycle(0, 0, 3'd0, 0, 8'd0, 5'b00010);

    // ch2: two writes before TC, last one wins
    cycle(0, 1, 3'd2, 1, 8'd5, 5'b00000);
    cycle(0, 0, 3'd0, 0, 8'd0, 5'b00000);
    cycle(0, 0, 3'd0, 0, 8'd0, 5'b00100);
    cycle(0, 1, 3'd2, 1, 8'd9, 5'b00100);
    cycle(0, 1, 3'd2, 1, 8'd2, 5'b00100);
    chk("ch2_pend_dbl", 32'(pending[2]), 32'd1);
    for (int k = 0; k < 12; k++) cycle(0, 0, 3'd0, 0, 8'd0, 5'b00100);

    // reset mid-period with ch3 pending, then ch3 runs at P=1
    cycle(0, 1, 3'd3, 0, 8'd3, 5'b00000);
    cycle(0, 0, 3'd0, 0, 8'd0, 5'b00000);
    cycle(0, 0, 3'd0, 0, 8'd0, 5'b01000);
    cycle(0, 0, 3'd0, 0, 8'd0, 5'b01000);
    cycle(0, 1, 3'd3, 0, 8'd2, 5'b01000);
    chk("ch3_pend_pre", 32'(pending[3]), 32'd1);
    cycle(1, 1, 3'd3, 1, 8'd6, 5'b11111);
    chk("rst_tick", 32'(tick_out), 32'd0);
    chk("rst_sq",   32'(sq_out),   32'd0);
    chk("rst_pend", 32'(pending),  32'd0);
    for (int k = 0; k < 5; k++) begin
      cycle(0, 0, 3'd0, 0, 8'd0, 5'b01000);
      chk("ch3_p1_tick", 32'(tick_out[3]), 32'd1);
      chk("ch3_p1_sq",   32'(sq_out[3]),   32'd0);
    end

    // out-of-range channel writes are dropped
    for (int c = 5; c < 8; c++) begin
      cycle(0, 1, 3'(c), 1, 8'd9, 5'b01000);
      chk("oor_pend", 32'(pending), 32'd0);
    end
    for (int k = 0; k < 4; k++) cycle(0, 0, 3'd0, 0, 8'd0, 5'b01000);

    en_r = '0;
    for (int k = 0; k < 3000; k++) begin
      logic r, w, m;
      logic [2:0] ch;
      logic [7:0] d;
      for (int i = 0; i < NCH; i++)
        if ($urandom_range(0, 15) == 0) en_r[i] = ~en_r[i];
      r  = ($urandom_range(0, 299) == 0);
      w  = ($urandom_range(0, 3) == 0);
      ch = 3'($urandom_range(0, 7));
      m  = 1'($urandom_range(0, 1));
      d  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
      cycle(r, w, ch, m, d, en_r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
